// File: rtl/reg_demux_wdt.sv
// reg_demux_wdt
//   Fans one register-bus master out to NumPorts register targets. It decodes
//   the address against per-port [start, end) rules, with an optional default
//   route. Requests that miss (DECERR) get an error response. Each access is
//   guarded by a watchdog. A target that does not answer within TimeoutCycles
//   is aborted with an error response and quarantined. A quarantined target
//   refuses new accesses until software clears it.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_*                     upstream request (addr/write/wdata/wstrb/valid)
//                            and response (rdata/error/ready strobe)
//   out_addr/write/wdata/wstrb_o
//                            registered request, broadcast to all targets
//   out_valid_o              one-hot request valid towards the selected target
//   out_rdata/error/ready_i  per-target responses
//   rule_start_i, rule_end_i per-port decode window, port p in slice p
//   en_default_i, default_idx_i
//                            default route for decode misses
//   clear_quarantine_i       per-port level clear of the quarantine flag
//   quarantine_o             sticky per-port quarantine flags
//   timeout_o, timeout_idx_o abort pulse and index of the last aborted port
module reg_demux_wdt #(
  parameter int NumPorts      = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256,
  parameter int IdxWidth      = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [AddrWidth-1:0]            in_addr_i,
  input  logic                            in_write_i,
  input  logic [DataWidth-1:0]            in_wdata_i,
  input  logic [DataWidth/8-1:0]          in_wstrb_i,
  input  logic                            in_valid_i,
  output logic [DataWidth-1:0]            in_rdata_o,
  output logic                            in_error_o,
  output logic                            in_ready_o,
  output logic [AddrWidth-1:0]            out_addr_o,
  output logic                            out_write_o,
  output logic [DataWidth-1:0]            out_wdata_o,
  output logic [DataWidth/8-1:0]          out_wstrb_o,
  output logic [NumPorts-1:0]             out_valid_o,
  input  logic [NumPorts*DataWidth-1:0]   out_rdata_i,
  input  logic [NumPorts-1:0]             out_error_i,
  input  logic [NumPorts-1:0]             out_ready_i,
  input  logic [NumPorts*AddrWidth-1:0]   rule_start_i,
  input  logic [NumPorts*AddrWidth-1:0]   rule_end_i,
  input  logic                            en_default_i,
  input  logic [IdxWidth-1:0]             default_idx_i,
  input  logic [NumPorts-1:0]             clear_quarantine_i,
  output logic [NumPorts-1:0]             quarantine_o,
  output logic                            timeout_o,
  output logic [IdxWidth-1:0]             timeout_idx_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int CntWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] CntMax =
    (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
  logic [IdxWidth-1:0]    sel_q, sel_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   error_q, error_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [NumPorts-1:0]    quar_q, quar_d;
  logic                   timeout_q, timeout_d;
  logic [IdxWidth-1:0]    tidx_q, tidx_d;

  // Address decode
  logic                   dec_hit;
  logic [IdxWidth-1:0]    dec_sel;
  logic                   dflt_ok;
  logic                   dec_ok;
  logic [IdxWidth-1:0]    tgt;
  logic                   tgt_quar;

  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    // Walk downwards so the lowest matching index is the one that sticks.
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if ((in_addr_i >= rule_start_i[p*AddrWidth +: AddrWidth]) &&
          (in_addr_i <  rule_end_i[p*AddrWidth +: AddrWidth])) begin
        dec_hit = 1'b1;
        dec_sel = IdxWidth'(p);
      end
    end
    // An out-of-range default index is treated as a decode error.
    dflt_ok  = ({{(32-IdxWidth){1'b0}}, default_idx_i} < 32'(NumPorts));
    dec_ok   = dec_hit | (en_default_i & dflt_ok);
    tgt      = dec_hit ? dec_sel : default_idx_i;
    tgt_quar = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      if (tgt == IdxWidth'(p)) tgt_quar = quar_q[p];
    end
  end

  // Selected-target view of the downstream response
  logic [NumPorts-1:0]    sel_onehot;
  logic                   sel_ready;
  logic                   sel_error;
  logic [DataWidth-1:0]   sel_rdata;

  always_comb begin
    sel_onehot = '0;
    sel_ready  = 1'b0;
    sel_error  = 1'b0;
    sel_rdata  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (sel_q == IdxWidth'(p)) begin
        sel_onehot[p] = 1'b1;
        sel_ready     = out_ready_i[p];
        sel_error     = out_error_i[p];
        sel_rdata     = out_rdata_i[p*DataWidth +: DataWidth];
      end
    end
  end

  // Transaction FSM, watchdog and quarantine
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    cnt_d     = cnt_q;
    quar_d    = quar_q;
    timeout_d = 1'b0;
    tidx_d    = tidx_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          addr_d  = in_addr_i;
          write_d = in_write_i;
          wdata_d = in_wdata_i;
          wstrb_d = in_wstrb_i;
          sel_d   = tgt;
          cnt_d   = '0;
          if (dec_ok && !tgt_quar) begin
            state_d = ACCESS;
          end else begin
            state_d = RESP;
            rdata_d = '0;
            error_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        // A ready in the final watchdog cycle still completes normally.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          error_d = sel_error;
          state_d = RESP;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntMax)) begin
          quar_d    = quar_q | sel_onehot;
          timeout_d = 1'b1;
          tidx_d    = sel_q;
          rdata_d   = '0;
          error_d   = 1'b1;
          state_d   = RESP;
        end else if (TimeoutCycles != 0) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      RESP: begin
        // Any in_valid_i seen here belongs to the transaction being answered.
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // Software clear wins over a same-cycle abort of that port.
    quar_d = quar_d & ~clear_quarantine_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
      quar_q    <= '0;
      timeout_q <= 1'b0;
      tidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
      quar_q    <= quar_d;
      timeout_q <= timeout_d;
      tidx_q    <= tidx_d;
    end
  end

  // Outputs are decoded from state so an asynchronous reset drops them at once.
  assign out_addr_o    = addr_q;
  assign out_write_o   = write_q;
  assign out_wdata_o   = wdata_q;
  assign out_wstrb_o   = wstrb_q;
  assign out_valid_o   = (state_q == ACCESS) ? sel_onehot : '0;
  assign in_ready_o    = (state_q == RESP);
  assign in_rdata_o    = (state_q == RESP) ? rdata_q : '0;
  assign in_error_o    = (state_q == RESP) ? error_q : 1'b0;
  assign quarantine_o  = quar_q;
  assign timeout_o     = timeout_q;
  assign timeout_idx_o = tidx_q;

endmodule

// File: tb/tb_reg_demux_wdt.sv
module tb_reg_demux_wdt;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int IW = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [AW-1:0]     in_addr_i;
  logic              in_write_i;
  logic [DW-1:0]     in_wdata_i;
  logic [DW/8-1:0]   in_wstrb_i;
  logic              in_valid_i;
  logic [DW-1:0]     in_rdata_o;
  logic              in_error_o;
  logic              in_ready_o;
  logic [AW-1:0]     out_addr_o;
  logic              out_write_o;
  logic [DW-1:0]     out_wdata_o;
  logic [DW/8-1:0]   out_wstrb_o;
  logic [NP-1:0]     out_valid_o;
  logic [NP*DW-1:0]  out_rdata_i;
  logic [NP-1:0]     out_error_i;
  logic [NP-1:0]     out_ready_i;
  logic [NP*AW-1:0]  rule_start_i;
  logic [NP*AW-1:0]  rule_end_i;
  logic              en_default_i;
  logic [IW-1:0]     default_idx_i;
  logic [NP-1:0]     clear_quarantine_i;
  logic [NP-1:0]     quarantine_o;
  logic              timeout_o;
  logic [IW-1:0]     timeout_idx_o;

  int n_checks = 0;
  int n_err    = 0;

  reg_demux_wdt #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_addr_i(in_addr_i), .in_write_i(in_write_i), .in_wdata_i(in_wdata_i),
    .in_wstrb_i(in_wstrb_i), .in_valid_i(in_valid_i),
    .in_rdata_o(in_rdata_o), .in_error_o(in_error_o), .in_ready_o(in_ready_o),
    .out_addr_o(out_addr_o), .out_write_o(out_write_o), .out_wdata_o(out_wdata_o),
    .out_wstrb_o(out_wstrb_o), .out_valid_o(out_valid_o),
    .out_rdata_i(out_rdata_i), .out_error_i(out_error_i), .out_ready_i(out_ready_i),
    .rule_start_i(rule_start_i), .rule_end_i(rule_end_i),
    .en_default_i(en_default_i), .default_idx_i(default_idx_i),
    .clear_quarantine_i(clear_quarantine_i), .quarantine_o(quarantine_o),
    .timeout_o(timeout_o), .timeout_idx_o(timeout_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    in_addr_i  = a;
    in_write_i = w;
    in_wdata_i = d;
    in_wstrb_i = 4'hF;
    in_valid_i = 1'b1;
  endtask

  initial begin
    rst_ni             = 1'b0;
    in_addr_i          = '0;
    in_write_i         = 1'b0;
    in_wdata_i         = '0;
    in_wstrb_i         = '0;
    in_valid_i         = 1'b0;
    out_rdata_i        = '0;
    out_error_i        = '0;
    out_ready_i        = '0;
    rule_start_i       = {32'h0000_1000, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
    rule_end_i         = {32'h0000_1100, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    en_default_i       = 1'b0;
    default_idx_i      = '0;
    clear_quarantine_i = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_out_valid", 64'(out_valid_o), 64'h0);
    chk("rst_in_ready", 64'(in_ready_o), 64'h0);
    chk("rst_in_rdata", 64'(in_rdata_o), 64'h0);
    chk("rst_quarantine", 64'(quarantine_o), 64'h0);
    chk("rst_timeout", 64'(timeout_o), 64'h0);
    chk("rst_timeout_idx", 64'(timeout_idx_o), 64'h0);
    chk("rst_out_addr", 64'(out_addr_o), 64'h0);
    rst_ni = 1'b1;
    cyc();

    // 1: read 0x104 hits port 1, target ready on first ACCESS cycle
    out_ready_i = 4'b0010;
    out_rdata_i[1*DW +: DW] = 32'h0000_CAFE;
    req(32'h104, 1'b0, 32'h0);
    cyc();
    chk("t1_valid_access", 64'(out_valid_o), 64'h2);
    chk("t1_ready_early", 64'(in_ready_o), 64'h0);
    chk("t1_out_addr", 64'(out_addr_o), 64'h104);
    cyc();
    chk("t1_valid_resp", 64'(out_valid_o), 64'h0);
    chk("t1_ready", 64'(in_ready_o), 64'h1);
    chk("t1_rdata", 64'(in_rdata_o), 64'hCAFE);
    chk("t1_error", 64'(in_error_o), 64'h0);
    in_valid_i  = 1'b0;
    out_ready_i = '0;
    cyc();
    chk("t1_ready_drop", 64'(in_ready_o), 64'h0);
    chk("t1_rdata_zero", 64'(in_rdata_o), 64'h0);

    // 2: write 0x300 misses, no default -> DECERR after one cycle
    out_ready_i = 4'b1111;
    req(32'h300, 1'b1, 32'h1111_2222);
    cyc();
    chk("t2_valid", 64'(out_valid_o), 64'h0);
    chk("t2_ready", 64'(in_ready_o), 64'h1);
    chk("t2_error", 64'(in_error_o), 64'h1);
    chk("t2_rdata", 64'(in_rdata_o), 64'h0);
    chk("t2_out_write", 64'(out_write_o), 64'h1);
    in_valid_i = 1'b0;
    cyc();
    // 2b: same miss with default route to port 0
    en_default_i  = 1'b1;
    default_idx_i = 2'd0;
    out_ready_i   = 4'b0001;
    req(32'h300, 1'b1, 32'hA5A5_A5A5);
    cyc();
    chk("t2b_valid", 64'(out_valid_o), 64'h1);
    chk("t2b_wdata", 64'(out_wdata_o), 64'hA5A5_A5A5);
    cyc();
    chk("t2b_ready", 64'(in_ready_o), 64'h1);
    chk("t2b_error", 64'(in_error_o), 64'h0);
    in_valid_i   = 1'b0;
    out_ready_i  = '0;
    en_default_i = 1'b0;
    cyc();

    // 3: port 2 never ready -> 8 ACCESS cycles then abort
    out_rdata_i[2*DW +: DW] = 32'h0000_DEAD;
    req(32'h204, 1'b0, 32'h0);
    cyc();
    for (int i = 0; i < TO; i++) begin
      chk($sformatf("t3_valid_c%0d", i), 64'(out_valid_o), 64'h4);
      chk($sformatf("t3_no_to_c%0d", i), 64'(timeout_o), 64'h0);
      cyc();
    end
    chk("t3_valid_after", 64'(out_valid_o), 64'h0);
    chk("t3_ready", 64'(in_ready_o), 64'h1);
    chk("t3_error", 64'(in_error_o), 64'h1);
    chk("t3_rdata", 64'(in_rdata_o), 64'h0);
    chk("t3_timeout", 64'(timeout_o), 64'h1);
    chk("t3_timeout_idx", 64'(timeout_idx_o), 64'h2);
    chk("t3_quarantine", 64'(quarantine_o), 64'h4);
    in_valid_i = 1'b0;
    cyc();
    chk("t3_timeout_pulse", 64'(timeout_o), 64'h0);
    chk("t3_idx_held", 64'(timeout_idx_o), 64'h2);
    chk("t3_quar_sticky", 64'(quarantine_o), 64'h4);

    // 4: quarantined port refuses, then clear and retry
    out_ready_i = 4'b0100;
    out_rdata_i[2*DW +: DW] = 32'h0000_BEEF;
    req(32'h208, 1'b0, 32'h0);
    cyc();
    chk("t4_q_valid", 64'(out_valid_o), 64'h0);
    chk("t4_q_ready", 64'(in_ready_o), 64'h1);
    chk("t4_q_error", 64'(in_error_o), 64'h1);
    in_valid_i = 1'b0;
    cyc();
    clear_quarantine_i = 4'b0100;
    cyc();
    clear_quarantine_i = '0;
    chk("t4_cleared", 64'(quarantine_o), 64'h0);
    req(32'h208, 1'b0, 32'h0);
    cyc();
    chk("t4_valid", 64'(out_valid_o), 64'h4);
    cyc();
    chk("t4_ready", 64'(in_ready_o), 64'h1);
    chk("t4_rdata", 64'(in_rdata_o), 64'hBEEF);
    chk("t4_error", 64'(in_error_o), 64'h0);
    in_valid_i  = 1'b0;
    out_ready_i = '0;
    cyc();

    // 5: ready arrives in the last watchdog cycle -> normal completion
    out_rdata_i[0 +: DW] = 32'h0000_5555;
    req(32'h10, 1'b0, 32'h0);
    cyc();
    for (int i = 0; i < TO - 1; i++) cyc();
    chk("t5_valid_last", 64'(out_valid_o), 64'h1);
    out_ready_i = 4'b0001;
    cyc();
    chk("t5_ready", 64'(in_ready_o), 64'h1);
    chk("t5_rdata", 64'(in_rdata_o), 64'h5555);
    chk("t5_error", 64'(in_error_o), 64'h0);
    chk("t5_no_timeout", 64'(timeout_o), 64'h0);
    chk("t5_no_quar", 64'(quarantine_o), 64'h0);
    in_valid_i  = 1'b0;
    out_ready_i = '0;
    cyc();

    // 6: asynchronous reset in the middle of an access
    req(32'h104, 1'b0, 32'h0);
    cyc();
    chk("t6_valid_pre", 64'(out_valid_o), 64'h2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_valid_async", 64'(out_valid_o), 64'h0);
    chk("t6_ready_async", 64'(in_ready_o), 64'h0);
    in_valid_i = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();
    chk("t6_ready_after", 64'(in_ready_o), 64'h0);
    chk("t6_valid_after", 64'(out_valid_o), 64'h0);
    chk("t6_quar_after", 64'(quarantine_o), 64'h0);
    // back in IDLE: a fresh access behaves normally
    out_ready_i = 4'b0010;
    out_rdata_i[1*DW +: DW] = 32'h0000_CAFE;
    req(32'h104, 1'b0, 32'h0);
    cyc();
    chk("t6_post_valid", 64'(out_valid_o), 64'h2);
    cyc();
    chk("t6_post_rdata", 64'(in_rdata_o), 64'hCAFE);
    in_valid_i  = 1'b0;
    out_ready_i = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
